// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: merges single-cycle writeback (A) with buffered
// long-latency writeback (B) and tracks pending long-latency destinations for decode.
module regfile_wb_ctrl #(
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rsv_valid_i,
  input  logic [AWIDTH-1:0] rsv_addr_i,
  output logic              rsv_ready_o,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [AWIDTH-1:0] a_addr_i,
  input  logic [DWIDTH-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [AWIDTH-1:0] b_addr_i,
  input  logic [DWIDTH-1:0] b_data_i,
  output logic              rf_wen_o,
  output logic [AWIDTH-1:0] rf_waddr_o,
  output logic [DWIDTH-1:0] rf_wdata_o,
  input  logic [AWIDTH-1:0] q_addr1_i,
  input  logic [AWIDTH-1:0] q_addr2_i,
  output logic              q_busy1_o,
  output logic              q_busy2_o
);

  localparam int unsigned NumRegs = 2 ** AWIDTH;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
  localparam logic [PtrW:0]   FifoFull  = (PtrW + 1)'(FIFO_DEPTH);

  logic [AWIDTH-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [DWIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic [CntW-1:0]    starve_q, starve_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_src_b_q;

  logic fifo_empty, fifo_full, push, force_b, a_commit, b_commit;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FifoFull);
  assign b_ready_o  = !fifo_full;
  assign push       = b_valid_i && !fifo_full;

  // A starved head takes the port for exactly one cycle.
  assign force_b    = !fifo_empty && (starve_q == StarveMax);
  assign a_ready_o  = !force_b;
  assign a_commit   = a_valid_i && !force_b;
  assign b_commit   = !fifo_empty && !a_commit;

  assign rsv_ready_o = (rsv_addr_i == '0) || !busy_q[rsv_addr_i];
  assign q_busy1_o   = busy_q[q_addr1_i];
  assign q_busy2_o   = busy_q[q_addr2_i];

  always_comb begin
    busy_d = busy_q;
    if (rf_wen_o && rf_src_b_q) busy_d[rf_waddr_o] = 1'b0;
    if (rsv_valid_i && rsv_ready_o && (rsv_addr_i != '0)) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || b_commit) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !b_commit) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push && b_commit) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= b_addr_i;
      fifo_data_q[wr_ptr_q] <= b_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      rf_wen_o   <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      rf_src_b_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      if (push)     wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (b_commit) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (a_commit) begin
        rf_wen_o   <= (a_addr_i != '0);
        rf_waddr_o <= a_addr_i;
        rf_wdata_o <= a_data_i;
        rf_src_b_q <= 1'b0;
      end else if (b_commit) begin
        rf_wen_o   <= (fifo_addr_q[rd_ptr_q] != '0);
        rf_waddr_o <= fifo_addr_q[rd_ptr_q];
        rf_wdata_o <= fifo_data_q[rd_ptr_q];
        rf_src_b_q <= 1'b1;
      end else begin
        rf_wen_o <= 1'b0;
      end
    end
  end

endmodule
